// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI path: HS/VS/DE, early pixel requests,
// and a frame-synchronous mux between upstream pixels and built-in test patterns.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int REQ_LEAD = 2,
  parameter int CNT_W    = 12
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic [15:0]      pattern_color,
  input  logic [15:0]      pixel_data,
  input  logic             pixel_valid,
  output logic             data_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [23:0]      video_rgb,
  output logic             frame_start,
  output logic             underflow
);

  // Request handshake: data_req high in cycle k asks for (pixel_xpos, pixel_ypos).
  // Upstream answers with pixel_data/pixel_valid held across the edge that ends
  // cycle k+REQ_LEAD-1; pixel_valid low there is an underflow in pass-through mode.

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int BAR_W   = H_ACTIVE >> 3;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S    = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E    = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] H_REQ_S    = CNT_W'(H_SYNC + H_BP - REQ_LEAD);
  localparam logic [CNT_W-1:0] H_REQ_E    = CNT_W'(H_SYNC + H_BP - REQ_LEAD + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_S    = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);
  localparam logic [3:0]       BAR_IDLE   = (BAR_W == 0) ? 4'd8 : 4'd0;
  localparam logic [23:0]      WHITE      = 24'hFFFFFF;
  localparam logic [23:0]      BLACK      = 24'h000000;

  if (REQ_LEAD < 1 || REQ_LEAD > H_BP) begin : g_bad_lead
    $error("REQ_LEAD must lie in 1..H_BP");
  end
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
    $error("all timing parameters must be positive");
  end
  if (CNT_W < 5 || H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_width
    $error("CNT_W too narrow for the raster");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt, x_req, y_act, bar_pix;
  logic [4:0]       x_lo;
  logic [3:0]       bar_idx;
  logic [1:0]       mode_q;
  logic             h_wrap, h_sync_c, v_sync_c, h_act_c, h_req_c, v_act_c;
  logic             de_c, req_c, frame_c, uf_c;
  logic [23:0]      pix_c;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
    return {c[15:11], 3'b000, c[10:5], 2'b00, c[4:0], 3'b000};
  endfunction

  function automatic logic [23:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return 24'hFFFFFF;
      4'd1:    return 24'hF8FC00;
      4'd2:    return 24'h00FCF8;
      4'd3:    return 24'h00FC00;
      4'd4:    return 24'hF800F8;
      4'd5:    return 24'hF80000;
      4'd6:    return 24'h0000F8;
      default: return 24'h000000;
    endcase
  endfunction

  always_comb begin
    h_wrap   = (h_cnt == H_LAST);
    h_sync_c = (h_cnt < H_SYNC_END);
    v_sync_c = (v_cnt < V_SYNC_END);
    h_act_c  = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
    h_req_c  = (h_cnt >= H_REQ_S) && (h_cnt < H_REQ_E);
    v_act_c  = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
    de_c     = h_act_c && v_act_c;
    req_c    = h_req_c && v_act_c;
    frame_c  = (h_cnt == '0) && (v_cnt == '0);
    x_req    = h_cnt - H_REQ_S;
    y_act    = v_cnt - V_ACT_S;
    x_lo     = 5'(h_cnt - H_ACT_S);
  end

  // Evaluated at the sampling edge: the counter then sits on the pixel being output.
  always_comb begin
    pix_c = BLACK;
    uf_c  = 1'b0;
    case (mode_q)
      2'd0: begin
        if (pixel_valid) begin
          pix_c = rgb565_to_888(pixel_data);
        end else begin
          pix_c = rgb565_to_888(pattern_color);
          uf_c  = de_c;
        end
      end
      2'd1:    pix_c = bar_color(bar_idx);
      2'd2:    pix_c = (x_lo == 5'd0 || y_act[4:0] == 5'd0) ? WHITE : BLACK;
      default: pix_c = rgb565_to_888(pattern_color);
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
    end else begin
      h_cnt <= h_cnt + ONE;
    end
  end

  // Bar position tracks the active column incrementally; index 8 means past the last bar.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (!h_act_c) begin
      bar_pix <= '0;
      bar_idx <= BAR_IDLE;
    end else if (bar_idx != 4'd8) begin
      if (bar_pix == BAR_LAST) begin
        bar_pix <= '0;
        bar_idx <= bar_idx + 4'd1;
      end else begin
        bar_pix <= bar_pix + ONE;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 2'd0;
      video_hs    <= ~HS_POL;
      video_vs    <= ~VS_POL;
      video_de    <= 1'b0;
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      video_rgb   <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      video_hs    <= h_sync_c ? HS_POL : ~HS_POL;
      video_vs    <= v_sync_c ? VS_POL : ~VS_POL;
      video_de    <= de_c;
      data_req    <= req_c;
      pixel_xpos  <= req_c ? x_req : '0;
      pixel_ypos  <= req_c ? y_act : '0;
      video_rgb   <= de_c ? pix_c : BLACK;
      frame_start <= frame_c;
      if (frame_c) begin
        mode_q <= mode_sel;
      end
      if (uf_c) begin
        underflow <= 1'b1;
      end else if (frame_c) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 24x8 raster: timing measurements per frame and
// a pixel scoreboard fed with hand-computed values for every mode.
module tb_video_timing_gen;
  localparam int CNT_W = 12;
  localparam int FRAME = 192;
  localparam logic [15:0] PAT = 16'hF800;

  logic             pixel_clk = 1'b0;
  logic             rst;
  logic [1:0]       mode_sel;
  logic [15:0]      pattern_color;
  logic [15:0]      pixel_data;
  logic             pixel_valid;
  logic             data_req;
  logic [CNT_W-1:0] pixel_xpos, pixel_ypos;
  logic             video_hs, video_vs, video_de;
  logic [23:0]      video_rgb;
  logic             frame_start, underflow;

  int         checks = 0;
  int         errors = 0;
  int         inj_x  = -1;
  logic [1:0] cur_mode;
  logic [24:0] exp_q[$];

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(2), .CNT_W(CNT_W)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .mode_sel(mode_sel),
    .pattern_color(pattern_color), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .frame_start(frame_start), .underflow(underflow)
  );

  // ---------------- clock / watchdog ----------------
  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixel for active column x, row y; bit 24 marks a value to compare.
  function automatic logic [24:0] exp_pixel(input logic [1:0] m, input int x, input int y,
                                            input int ux);
    case (m)
      2'd0: begin
        if (ux >= 0 && y == 2 && x == ux) return {1'b1, 24'hF80000};
        return {1'b1, 24'(x) << 3};
      end
      2'd1: begin
        if (x < 2)   return {1'b1, 24'hFFFFFF};
        if (x < 4)   return {1'b1, 24'hF8FC00};
        if (x >= 14) return {1'b1, 24'h000000};
        return {1'b0, 24'h000000};
      end
      2'd2:    return {1'b1, (x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h000000};
      default: return {1'b1, 24'hF80000};
    endcase
  endfunction

  // ---------------- upstream model: one register of latency ----------------
  initial begin
    logic [15:0] pend_d;
    logic        pend_v;
    pend_d      = '0;
    pend_v      = 1'b1;
    pixel_data  = '0;
    pixel_valid = 1'b1;
    forever begin
      @(negedge pixel_clk);
      pixel_data  = pend_d;
      pixel_valid = pend_v;
      pend_d = 16'(pixel_xpos);
      pend_v = !(data_req && inj_x >= 0 && pixel_ypos == 12'd2 && int'(pixel_xpos) == inj_x);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge pixel_clk) begin
    if (!rst) begin
      if (video_de) begin
        check("rgb_pending", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          logic [24:0] e;
          e = exp_q.pop_front();
          if (e[24]) check("rgb", 32'(video_rgb), 32'(e[23:0]));
        end
      end else begin
        check("rgb_blank", 32'(video_rgb), 32'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals();
    check("rst_hs", 32'(video_hs), 32'(0));
    check("rst_vs", 32'(video_vs), 32'(0));
    check("rst_flags", 32'({video_de, data_req, frame_start, underflow}), 32'(0));
    check("rst_rgb", 32'(video_rgb), 32'(0));
    check("rst_pos", 32'({pixel_xpos, pixel_ypos}), 32'(0));
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    @(negedge pixel_clk);
    while (!frame_start && n < 400) begin
      @(negedge pixel_clk);
      n++;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_reset_vals();
    exp_q.delete();
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1'b0;
    @(negedge pixel_clk);
    check("fs_after_rst", 32'(frame_start), 32'(1));
    check("hs_after_rst", 32'(video_hs), 32'(1));
    cur_mode = mode_sel;
  endtask

  // Called on the sample where frame_start is high; ends on the next frame's first sample.
  task automatic run_frame(input logic [1:0] next_mode, input int uf_x, input int rst_at);
    int hs_cnt, hs_rises, hs_r0, hs_r1, vs_cnt, de_cnt, de_rises, req_cnt, req_r0, de_r0, fs_extra;
    logic hs_p, de_p, req_p;
    logic [1:0] frame_mode;
    frame_mode = cur_mode;
    check("fs_s0", 32'(frame_start), 32'(1));
    check("vs_lead", 32'(video_vs), 32'(1));
    check("uf_clear", 32'(underflow), 32'(0));
    inj_x = uf_x;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 16; x++) exp_q.push_back(exp_pixel(frame_mode, x, y, uf_x));
    hs_cnt = int'(video_hs); vs_cnt = int'(video_vs);
    hs_rises = 0; de_cnt = 0; de_rises = 0; req_cnt = 0; fs_extra = 0;
    hs_r0 = -1; hs_r1 = -1; req_r0 = -1; de_r0 = -1;
    hs_p = video_hs; de_p = video_de; req_p = data_req;
    for (int s = 1; s <= FRAME; s++) begin
      @(negedge pixel_clk);
      if (s == rst_at) begin
        do_reset();
        return;
      end
      if (s == FRAME) begin
        check("fs_next", 32'(frame_start), 32'(1));
        check("vs_next", 32'(video_vs), 32'(1));
        break;
      end
      if (s == 100) mode_sel = next_mode;
      if (video_hs) hs_cnt++;
      if (video_hs && !hs_p) begin
        hs_rises++;
        if (hs_r0 < 0) hs_r0 = s; else if (hs_r1 < 0) hs_r1 = s;
      end
      if (video_vs) vs_cnt++;
      if (video_de) de_cnt++;
      if (video_de && !de_p) begin
        de_rises++;
        if (de_r0 < 0) de_r0 = s;
      end
      if (data_req) req_cnt++;
      if (data_req && !req_p && req_r0 < 0) req_r0 = s;
      if (frame_start) fs_extra++;
      hs_p = video_hs; de_p = video_de; req_p = data_req;
      if (s >= 76 && s < 92) check("req_xpos", 32'({data_req, pixel_xpos}), 32'({1'b1, 12'(s - 76)}));
      if (s == 92) check("req_end", 32'({data_req, pixel_xpos}), 32'(0));
      if (s == 124) check("ypos", 32'(pixel_ypos), 32'(2));
      if (uf_x >= 0 && s == 130) check("uf_before", 32'(underflow), 32'(0));
      if (uf_x >= 0 && s == 131) check("uf_set", 32'(underflow), 32'(1));
      if (s == FRAME - 1) begin
        check("vs_end_low", 32'(video_vs), 32'(0));
        check("uf_hold", 32'(underflow), 32'(uf_x >= 0 && frame_mode == 2'd0));
      end
    end
    check("hs_period", 32'(hs_r1 - hs_r0), 32'(24));
    check("hs_high", 32'(hs_cnt), 32'(16));
    check("hs_rises", 32'(hs_rises), 32'(7));
    check("vs_width", 32'(vs_cnt), 32'(24));
    check("de_cycles", 32'(de_cnt), 32'(64));
    check("de_lines", 32'(de_rises), 32'(4));
    check("req_cycles", 32'(req_cnt), 32'(64));
    check("req_lead", 32'(de_r0 - req_r0), 32'(2));
    check("fs_once", 32'(fs_extra), 32'(0));
    cur_mode = next_mode;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst           = 1'b1;
    mode_sel      = 2'd0;
    pattern_color = PAT;
    cur_mode      = 2'd0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_vals();
    rst = 1'b0;
    wait_fs(n);
    check("fs_first_cycle", 32'(n), 32'(0));
    run_frame(2'd0, -1, -1);   // pass-through, timing
    run_frame(2'd1,  5, -1);   // underflow on row 2, column 5
    run_frame(2'd0, -1, -1);   // colour bars, underflow cleared
    run_frame(2'd3, -1, -1);   // mode 3 requested mid-frame; frame stays pass-through
    run_frame(2'd2, -1, -1);   // solid pattern_color
    run_frame(2'd0, -1, -1);   // grid
    run_frame(2'd0, -1, 106);  // reset in the middle of an active line
    run_frame(2'd0, -1, -1);   // timing from (0,0) after reset
    repeat (4) @(negedge pixel_clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
